// File: rtl/lcd_host_feeder.sv
// lcd_host_feeder: buffers host commands and image bytes, then feeds the LCD controller under its busy handshake
module lcd_host_feeder #(
  parameter int IMG_PIX   = 36,
  parameter int CMD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] h_cmd,
  input  logic       h_cmd_valid,
  output logic       h_cmd_ready,
  input  logic [7:0] h_pix,
  input  logic       h_pix_valid,
  output logic       h_pix_ready,
  input  logic       lcd_busy,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] lcd_datain,
  output logic       cmd_err
);
  localparam int PW = $clog2(IMG_PIX + 1);
  localparam int AW = $clog2(CMD_DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, GUARD, WAIT_LO} state_t;
  state_t state, state_n;
  logic [2:0] fifo [CMD_DEPTH];
  logic [7:0] pbuf [IMG_PIX];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [PW-1:0] pix_cnt, k, k_n;
  logic [2:0] head, cmd_n;
  logic [7:0] data_n;
  logic push, pop, pix_we, pix_clr, pix_full, valid_n, err_n;
  assign head        = fifo[rd_ptr];
  assign pix_full    = pix_cnt == PW'(IMG_PIX);
  assign h_cmd_ready = cnt != (AW+1)'(CMD_DEPTH);
  assign h_pix_ready = !pix_full && state != STREAM;
  assign push        = h_cmd_valid && h_cmd_ready;
  assign pix_we      = h_pix_valid && h_pix_ready;
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    valid_n = 1'b0;
    err_n   = 1'b0;
    cmd_n   = lcd_cmd;
    data_n  = lcd_datain;
    k_n     = k;
    pix_clr = 1'b0;
    case (state)
      IDLE:
        if (cnt != '0 && !lcd_busy) begin
          if (head[2:1] == 2'b11) begin
            pop   = 1'b1;
            err_n = 1'b1;
          end else if (!(head == 3'd1 && !pix_full)) begin
            pop     = 1'b1;
            cmd_n   = head;
            valid_n = 1'b1;
            state_n = ISSUE;
          end
        end
      ISSUE: begin
        state_n = lcd_cmd == 3'd1 ? STREAM : GUARD;
        data_n  = lcd_cmd == 3'd1 ? pbuf[0] : lcd_datain;
        k_n     = '0;
      end
      STREAM:
        if (k == PW'(IMG_PIX - 1)) begin
          pix_clr = 1'b1;
          state_n = GUARD;
        end else begin
          data_n = pbuf[k + 1'b1];
          k_n    = k + 1'b1;
        end
      GUARD:   state_n = WAIT_LO;
      WAIT_LO: state_n = lcd_busy ? WAIT_LO : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      pix_cnt       <= '0;
      k             <= '0;
      lcd_cmd       <= '0;
      lcd_cmd_valid <= 1'b0;
      lcd_datain    <= '0;
      cmd_err       <= 1'b0;
    end else begin
      state         <= state_n;
      wr_ptr        <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr        <= pop ? rd_ptr + 1'b1 : rd_ptr;
      cnt           <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      pix_cnt       <= pix_clr ? '0 : pix_cnt + PW'(pix_we);
      k             <= k_n;
      lcd_cmd       <= cmd_n;
      lcd_cmd_valid <= valid_n;
      lcd_datain    <= data_n;
      cmd_err       <= err_n;
    end
  end
  // Storage arrays carry no reset; occupancy is tracked by cnt and pix_cnt.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= h_cmd;
    if (pix_we) pbuf[pix_cnt] <= h_pix;
  end
endmodule

// File: tb/tb_lcd_host_feeder.sv
// tb_lcd_host_feeder: directed scenarios plus random traffic checked every cycle against a timeline model
module tb_lcd_host_feeder;
  localparam int N = 36;
  logic clk = 0, reset = 1;
  logic [2:0] h_cmd = 0;
  logic h_cmd_valid = 0, h_pix_valid = 0, lcd_busy = 0;
  logic [7:0] h_pix = 0;
  logic h_cmd_ready, h_pix_ready, lcd_cmd_valid, cmd_err;
  logic [2:0] lcd_cmd;
  logic [7:0] lcd_datain;
  lcd_host_feeder #(.IMG_PIX(N), .CMD_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .h_cmd(h_cmd), .h_cmd_valid(h_cmd_valid), .h_cmd_ready(h_cmd_ready),
    .h_pix(h_pix), .h_pix_valid(h_pix_valid), .h_pix_ready(h_pix_ready), .lcd_busy(lcd_busy),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Model: command queue, image array, and a timeline counter t measured from the issue edge.
  int q[$];
  logic [7:0] img [N];
  int pix_n = 0, active = 0, is_load = 0, t = 0, m_cmd = 0, m_data = 0, m_valid = 0, m_err = 0;
  function automatic void m_reset();
    q.delete();
    pix_n = 0; active = 0; is_load = 0; t = 0; m_cmd = 0; m_data = 0; m_valid = 0; m_err = 0;
  endfunction
  function automatic int m_pix_ready();
    return int'(pix_n < N && !(active != 0 && is_load != 0 && t >= 1 && t <= N));
  endfunction
  function automatic int m_cmd_ready();
    return int'(q.size() < 4);
  endfunction
  function automatic void m_step();
    int pr, cr, w;
    pr = m_pix_ready();
    cr = m_cmd_ready();
    m_valid = 0;
    m_err = 0;
    if (active == 0) begin
      if (q.size() > 0 && !lcd_busy) begin
        if (q[0] > 5) begin
          void'(q.pop_front());
          m_err = 1;
        end else if (!(q[0] == 1 && pix_n < N)) begin
          m_cmd = q.pop_front();
          m_valid = 1; active = 1; t = 0; is_load = int'(m_cmd == 1);
        end
      end
    end else begin
      w = is_load != 0 ? N + 2 : 2;
      if (is_load != 0 && t < N) m_data = img[t];
      if (is_load != 0 && t == N) pix_n = 0;
      if (t < w) t++;
      else if (!lcd_busy) active = 0;
    end
    if (pr != 0 && h_pix_valid) begin
      img[pix_n] = h_pix;
      pix_n++;
    end
    if (cr != 0 && h_cmd_valid) q.push_back(int'(h_cmd));
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else begin
      m_step();
      #1;
      check("valid", lcd_cmd_valid, m_valid);
      check("cmd", lcd_cmd, m_cmd);
      check("datain", lcd_datain, m_data);
      check("err", cmd_err, m_err);
      check("cmd_ready", h_cmd_ready, m_cmd_ready());
      check("pix_ready", h_pix_ready, m_pix_ready());
    end
  end
  // Controller stand-in: busy after each issue, optionally forced or randomized.
  logic auto_busy = 0, force_busy = 0, rnd_busy = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (auto_busy && lcd_cmd_valid) busy_cnt = rnd_busy ? $urandom_range(0, 6) : 12;
    else if (busy_cnt > 0) busy_cnt--;
    lcd_busy = force_busy || busy_cnt > 0 || (rnd_busy && $urandom_range(0, 3) == 0);
  end
  int issued[$];
  int err_cnt = 0;
  always @(negedge clk) begin
    if (!reset && lcd_cmd_valid) issued.push_back(int'(lcd_cmd));
    if (!reset && cmd_err) err_cnt++;
  end
  task automatic push_cmd(input logic [2:0] c);
    h_cmd = c; h_cmd_valid = 1;
    @(negedge clk) h_cmd_valid = 0;
  endtask
  task automatic push_pix(input logic [7:0] b);
    h_pix = b; h_pix_valid = 1;
    @(negedge clk) h_pix_valid = 0;
  endtask
  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!lcd_cmd_valid && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_valid", lcd_cmd_valid, 1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int cyc;
    idle(3);
    check("rst_valid", lcd_cmd_valid, 0);
    check("rst_datain", lcd_datain, 0);
    check("rst_cmd_ready", h_cmd_ready, 1);
    check("rst_pix_ready", h_pix_ready, 1);
    check("rst_err", cmd_err, 0);
    reset = 0;
    idle(2);
    // Load with stall after 20 bytes
    issued.delete();
    push_cmd(3'd1);
    for (int i = 0; i < 20; i++) push_pix(8'(i));
    repeat (5) begin
      @(negedge clk);
      check("stall_no_issue", lcd_cmd_valid, 0);
    end
    for (int i = 20; i < N; i++) push_pix(8'(i));
    wait_valid(3, cyc);
    check("stall_latency_le2", int'(cyc <= 2), 1);
    check("load_cmd", lcd_cmd, 1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("stream_byte", lcd_datain, i);
    end
    idle(2);
    check("datain_hold", lcd_datain, 8'h23);
    check("load_one_issue", issued.size(), 1);
    // Handshake ordering
    auto_busy = 1;
    idle(3);
    issued.delete();
    push_cmd(3'd2);
    push_cmd(3'd4);
    push_cmd(3'd0);
    for (int c = 0; c < 120 && issued.size() < 3; c++) @(negedge clk);
    idle(20);
    check("hs_count", issued.size(), 3);
    check("hs_0", issued.size() > 0 ? issued[0] : -1, 2);
    check("hs_1", issued.size() > 1 ? issued[1] : -1, 4);
    check("hs_2", issued.size() > 2 ? issued[2] : -1, 0);
    // Illegal code dropped
    auto_busy = 0;
    idle(3);
    issued.delete();
    err_cnt = 0;
    push_cmd(3'd7);
    push_cmd(3'd3);
    idle(10);
    check("ill_err_cnt", err_cnt, 1);
    check("ill_issued", issued.size(), 1);
    check("ill_cmd", issued.size() > 0 ? issued[0] : -1, 3);
    // Full FIFO
    force_busy = 1;
    idle(2);
    issued.delete();
    for (int i = 0; i < 5; i++) begin
      check("full_ready", h_cmd_ready, int'(i < 4));
      push_cmd(3'(2 + (i % 4)));
    end
    check("full_ready_after", h_cmd_ready, 0);
    force_busy = 0;
    idle(30);
    check("full_issued", issued.size(), 4);
    for (int i = 0; i < 4; i++) check("full_order", issued.size() > i ? issued[i] : -1, 2 + i);
    // Reset mid-stream at byte 10
    idle(2);
    push_cmd(3'd1);
    push_cmd(3'd2);
    for (int i = 0; i < N; i++) push_pix(8'($urandom));
    wait_valid(4, cyc);
    repeat (11) @(negedge clk);
    #2 reset = 1;
    #1;
    check("mid_rst_valid", lcd_cmd_valid, 0);
    check("mid_rst_datain", lcd_datain, 0);
    check("mid_rst_pix_ready", h_pix_ready, 1);
    check("mid_rst_cmd_ready", h_cmd_ready, 1);
    @(negedge clk) reset = 0;
    issued.delete();
    idle(10);
    check("mid_rst_fifo_empty", issued.size(), 0);
    // Random traffic
    auto_busy = 1;
    rnd_busy = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      h_cmd_valid = $urandom_range(0, 9) == 0;
      h_cmd = 3'($urandom_range(0, 7));
      h_pix_valid = $urandom_range(0, 1) == 1;
      h_pix = 8'($urandom);
    end
    @(negedge clk);
    h_cmd_valid = 0;
    h_pix_valid = 0;
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
